// File: rtl/downcounter_timer_pkg.sv
// Shared constants and FSM state encoding for the down-counting timer.
package downcounter_timer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/downcounter_timer_if.sv
// Signal bundle for the timer's control and status lines; the controller
// drives the master side, the timer is the slave.
interface downcounter_timer_if
  import downcounter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic clock
);

  // Control inputs are level-sampled on every rising edge; there is no
  // valid/ready exchange: a command is taken on the edge where it is high.
  logic             start;
  logic             stop;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    input  clock,
    output start, stop, enable, auto_reload, load_value,
    input  count, busy, done, zero
  );

  modport slave (
    input  clock,
    input  start, stop, enable, auto_reload, load_value,
    output count, busy, done, zero
  );

endinterface

// File: rtl/downcounter_timer.sv
// Loadable down-counter with pause, abort, optional auto-reload and a
// registered one-cycle terminal-count pulse.
module downcounter_timer
  import downcounter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iStart,
  input  logic             iStop,
  input  logic             iEnable,
  input  logic             iAutoReload,
  input  logic [WIDTH-1:0] iLoadValue,
  output logic [WIDTH-1:0] oCount,
  output logic             oBusy,
  output logic             oDone,
  output logic             oZero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Edge priority: stop (only meaningful in RUN) beats start beats counting.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (iStop && (state_q == RUN)) begin
      state_d = IDLE;
    end else if (iStart) begin
      count_d = iLoadValue;
      if (iLoadValue == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        reload_d = iLoadValue;
        state_d  = RUN;
      end
    end else if ((state_q == RUN) && iEnable) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        // Terminal edge; the reload choice is made only here.
        done_d = 1'b1;
        if (iAutoReload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
    end
  end

  assign oCount = count_q;
  assign oBusy  = (state_q == RUN);
  assign oDone  = done_q;
  assign oZero  = (count_q == '0);

endmodule

// File: tb/tb_downcounter_timer.sv
// Bench for downcounter_timer: fixed vector table, hand-built multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_downcounter_timer;
  import downcounter_timer_pkg::*;

  localparam int W  = DEFAULT_WIDTH;
  localparam int EW = W + 3;

  typedef struct {
    logic         rst, st, sp, en, ar;
    logic [W-1:0] ld;
    logic [W-1:0] cnt;
    logic         busy, done, zero;
  } vec_t;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  downcounter_timer_if #(.WIDTH(W)) bus (.clock(clock));

  downcounter_timer #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .iStart      (bus.start),
    .iStop       (bus.stop),
    .iEnable     (bus.enable),
    .iAutoReload (bus.auto_reload),
    .iLoadValue  (bus.load_value),
    .oCount      (bus.count),
    .oBusy       (bus.busy),
    .oDone       (bus.done),
    .oZero       (bus.zero)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  vec_t          vecs[$];

  // behavioural reference: a running flag, a remaining count and the last
  // nonzero load, advanced one clock edge at a time from the stated rules
  bit           m_run = 1'b0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_count = '0;
  logic [W-1:0] m_reload = '0;

  task automatic model_edge(input logic rst, st, sp, en, ar, input logic [W-1:0] ld);
    if (rst) begin
      m_run = 0; m_done = 0; m_count = '0; m_reload = '0;
    end else begin
      m_done = 0;
      if (m_run && sp) begin
        m_run = 0;
      end else if (st) begin
        m_count = ld;
        if (ld == 0) begin
          m_run = 0; m_done = 1;
        end else begin
          m_run = 1; m_reload = ld;
        end
      end else if (m_run && en) begin
        if (m_count == 1) begin
          m_done  = 1;
          m_run   = ar;
          m_count = ar ? m_reload : '0;
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs, take one rising edge, advance model, settle
  task automatic drive(input logic rst, st, sp, en, ar, input logic [W-1:0] ld);
    reset           = rst;
    bus.start       = st;
    bus.stop        = sp;
    bus.enable      = en;
    bus.auto_reload = ar;
    bus.load_value  = ld;
    @(posedge clock);
    model_edge(rst, st, sp, en, ar, ld);
    exp_q.push_back({m_run, m_done, (m_count == '0), m_count});
    #1;
  endtask

  // scoreboard: compare outputs with the oldest model expectation
  task automatic check_model(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_queue: got empty expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_count"}, 32'(bus.count), 32'(e[W-1:0]));
    check({tag, "_zero"},  32'(bus.zero),  32'(e[W]));
    check({tag, "_done"},  32'(bus.done),  32'(e[W+1]));
    check({tag, "_busy"},  32'(bus.busy),  32'(e[W+2]));
  endtask

  function automatic vec_t mk(input logic rst, st, sp, en, ar, input logic [W-1:0] ld,
                              input logic [W-1:0] cnt, input logic busy, done, zero);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.en = en; v.ar = ar; v.ld = ld;
    v.cnt = cnt; v.busy = busy; v.done = done; v.zero = zero;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    vec_t v;
    bit ar;

    // basic countdown of 5
    vecs.push_back(mk(1,0,0,0,0,0,   0,0,0,1));
    vecs.push_back(mk(0,1,0,1,0,5,   5,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   4,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   3,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   2,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   1,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   0,0,1,1));
    vecs.push_back(mk(0,0,0,1,0,0,   0,0,0,1));
    // zero load
    vecs.push_back(mk(0,1,0,1,0,0,   0,0,1,1));
    vecs.push_back(mk(0,0,0,1,0,0,   0,0,0,1));
    // pause at 2, abort at 1, then stop/enable ignored in idle
    vecs.push_back(mk(0,1,0,1,0,4,   4,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   3,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   2,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,   2,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,   2,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   1,1,0,0));
    vecs.push_back(mk(0,0,1,1,0,0,   1,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   1,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,0,   1,0,0,0));
    // restart at 7 with 10
    vecs.push_back(mk(0,1,0,1,0,9,   9,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   8,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   7,1,0,0));
    vecs.push_back(mk(0,1,0,1,0,10, 10,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   9,1,0,0));
    // reset at 6 with start high, then start honoured right after reset
    vecs.push_back(mk(0,0,0,1,0,0,   8,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   7,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,   6,1,0,0));
    vecs.push_back(mk(1,1,0,1,1,20,  0,0,0,1));
    vecs.push_back(mk(0,1,0,1,0,3,   3,1,0,0));
    vecs.push_back(mk(0,0,1,1,0,0,   3,0,0,0));
    // stop outranks start in RUN
    vecs.push_back(mk(0,1,0,1,0,5,   5,1,0,0));
    vecs.push_back(mk(0,1,1,1,0,7,   5,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.st, v.sp, v.en, v.ar, v.ld);
      check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(v.cnt));
      check($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(v.busy));
      check($sformatf("vec%0d_done", i),  32'(bus.done),  32'(v.done));
      check($sformatf("vec%0d_zero", i),  32'(bus.zero),  32'(v.zero));
    end

    // auto-reload of 3; auto_reload only matters on terminal edges
    drive(0, 1, 0, 1, 1, 3);
    check("ar_start_count", 32'(bus.count), 32'd3);
    for (int k = 1; k <= 15; k++) begin
      if (k % 3 == 0) ar = (k != 15);
      else            ar = 1'($urandom_range(0, 1));
      drive(0, 0, 0, 1, ar, 0);
      if (k < 15) begin
        check($sformatf("ar%0d_count", k), 32'(bus.count), 32'(3 - (k % 3)));
        check($sformatf("ar%0d_busy", k),  32'(bus.busy),  32'd1);
        check($sformatf("ar%0d_done", k),  32'(bus.done),  32'(k % 3 == 0));
      end else begin
        check("ar_end_count", 32'(bus.count), 32'd0);
        check("ar_end_busy",  32'(bus.busy),  32'd0);
        check("ar_end_done",  32'(bus.done),  32'd1);
      end
    end
    drive(0, 0, 0, 1, 1, 0);
    check("ar_after_done", 32'(bus.done), 32'd0);

    // full-range load: terminal pulse exactly 255 edges after start
    drive(0, 1, 0, 1, 0, 8'd255);
    check("wide_start_count", 32'(bus.count), 32'd255);
    seen = 0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      drive(0, 0, 0, 1, 0, 0);
      if (bus.done === 1'b1) begin
        seen = 1;
        check("wide_done_edge", 32'(k), 32'd255);
        check("wide_end_count", 32'(bus.count), 32'd0);
        check("wide_end_busy",  32'(bus.busy),  32'd0);
      end else if (k <= 255) begin
        check($sformatf("wide%0d_count", k), 32'(bus.count), 32'(255 - k));
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL wide_done_timeout: got no done pulse expected one within 300 edges");
    end

    // randomized traffic against the model
    exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      logic rst, st, sp, en, arr;
      logic [W-1:0] ld;
      rst = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 15) == 0);
      sp  = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 3) != 0);
      arr = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
      drive(rst, st, sp, en, arr, ld);
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/downcounter_timer.md
DOWNCOUNTER_TIMER -- requirements
Module: downcounter_timer

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, bit width of count and load value.
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: iStart  input  1  load iLoadValue and begin a countdown.
REQ-005 SHALL have port: iStop  input  1  abort countdown, return to IDLE.
REQ-006 SHALL have port: iEnable  input  1  count when high, hold when low.
REQ-007 SHALL have port: iAutoReload  input  1  on terminal count, reload and continue.
REQ-008 SHALL have port: iLoadValue  input  WIDTH  countdown start value N.
REQ-009 SHALL have port: oCount  output  WIDTH  current registered count.
REQ-010 SHALL have port: oBusy  output  1  high while in RUN.
REQ-011 SHALL have port: oDone  output  1  registered single-cycle terminal-count pulse.
REQ-012 SHALL have port: oZero  output  1  combinational, equals (oCount == 0).

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN; oBusy is high exactly when the state is RUN.
REQ-014 SHALL apply per-edge priority: reset > iStop > iStart > count/hold.
REQ-015 SHALL, in IDLE with iStart=1 and iLoadValue=N>0, set oCount=N, store N in an internal reload register, and enter RUN on that edge.
REQ-016 SHALL, in IDLE with iStart=1 and iLoadValue=0, set oCount=0, assert oDone for the next cycle, and remain in IDLE.
REQ-017 SHALL, in RUN with iEnable=1 and oCount>1, decrement oCount by 1 per edge.
REQ-018 SHALL, in RUN with iEnable=1 and oCount==1, assert oDone for the following cycle.
REQ-019 SHALL, on the same edge as REQ-018, load oCount with the reload register and stay in RUN if iAutoReload=1; otherwise set oCount=0 and enter IDLE.
REQ-020 SHALL sample iAutoReload only at the terminal-count edge.
REQ-021 SHALL, in RUN with iEnable=0, hold oCount and the state; oDone stays 0.
REQ-022 SHALL, on iStop=1 in RUN, hold oCount, enter IDLE, and leave oDone at 0, including when oCount==1 on that edge.
REQ-023 SHALL, on iStart=1 in RUN, restart exactly as REQ-015/016 with no oDone for the aborted countdown.
REQ-024 SHALL produce timing of N edges after the start edge: count N after the start edge, oDone high in the cycle after edge N (continuous enable), auto-reload period exactly N cycles.
REQ-025 SHALL ignore iStop in IDLE, ignore iEnable in IDLE, and never let oCount wrap below 0.
REQ-026 SHALL keep oDone low in every cycle not covered by REQ-016/018.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, set state=IDLE, oCount=0, reload register=0, oDone=0, oBusy=0, regardless of other inputs or a countdown in progress.
REQ-028 SHALL resume normal operation on the first edge with reset=0; iStart on that edge is honoured.

Structure
REQ-029 SHALL place the FSM state encodings (IDLE, RUN) and the default WIDTH constant in the shared timer/counter package.
REQ-030 SHALL be a single module with no sub-modules; FSM, count register, reload register and done register all reside in downcounter_timer.

Verification (WIDTH=8)
REQ-031 SHALL cover basic countdown: reset, then iStart with iLoadValue=5, iEnable=1, iAutoReload=0 -> oCount 5,4,3,2,1,0; oDone high in exactly one cycle, 5 cycles after start; oBusy drops with it; oZero=1.
REQ-032 SHALL cover auto-reload: iLoadValue=3, iAutoReload=1 held -> oCount 3,2,1,3,2,1...; oDone pulses every 3 cycles; oBusy stays 1.
REQ-033 SHALL cover pause and abort: iLoadValue=4, iEnable low for 2 cycles at count 2 -> count holds at 2 for those cycles; iStop at count 1 -> oCount stays 1, IDLE, no oDone.
REQ-034 SHALL cover zero load and restart: iStart with 0 -> one oDone pulse, oBusy=0; in RUN at count 7, iStart with 10 -> oCount=10, no oDone.
REQ-035 SHALL cover reset mid-run: reset asserted at count 6 with iStart=1 -> oCount=0, oBusy=0, oDone=0 next cycle.
REQ-036 SHALL cover the wide boundary: iLoadValue=255 with continuous enable -> oDone exactly 255 cycles after start, no wrap.
